// File: rtl/prover_v_update_elem.sv
// prover_v_update_elem
// Serial fold element for the sum-check prover. It computes
// out = V0 + tau*(V1 - V0) mod Q for one shuffled pair. The product uses a
// bit-serial double-and-add multiplier that scans tau MSB-first.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   en     in   1      start request, sampled only while ready=1
//   in_0   in   NBITS  V0, canonical (< Q)
//   in_1   in   NBITS  V1, canonical (< Q)
//   tau    in   NBITS  round challenge, canonical (< Q)
//   out    out  NBITS  registered folded result, held until the next ADD edge
//   ready  out  1      idle; out holds the last completed result
//
// state | meaning
// IDLE  | waiting for en; out holds the last result
// SUB   | d <- (a1 - a0) mod Q, clear accumulator, load bit counter
// MUL   | one double-and-add step per edge over t, MSB first
// ADD   | out <- (acc + a0) mod Q, then return to IDLE

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 16'd65521
`endif

module prover_v_update_elem #(
    parameter int                NBITS = `F_NBITS,
    parameter logic [NBITS-1:0]  Q     = `F_Q
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NBITS-1:0] in_0,
    input  logic [NBITS-1:0] in_1,
    input  logic [NBITS-1:0] tau,
    output logic [NBITS-1:0] out,
    output logic             ready
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MUL  = 2'd2,
        ADD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NBITS-1:0] a0, a1, t, d, acc;
    logic [CW-1:0]    cnt;

    logic accept, do_sub, do_mul, do_add;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en)         state_nxt = SUB;
            SUB:                  state_nxt = MUL;
            MUL:  if (cnt == '0)  state_nxt = ADD;
            ADD:                  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        do_sub = 1'b0;
        do_mul = 1'b0;
        do_add = 1'b0;
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = en;
            end
            SUB:     do_sub = 1'b1;
            MUL:     do_mul = 1'b1;
            ADD:     do_add = 1'b1;
            default: ready  = 1'b0;
        endcase
    end

    // One multiplier step. With acc < Q and d < Q the doubled sum stays
    // below 3Q, so two conditional subtractions bring it back under Q.
    logic [NBITS+1:0] qx, s, s1, s2;
    always_comb begin
        qx = {2'b00, Q};
        s  = {1'b0, acc, 1'b0} + {2'b00, (d & {NBITS{t[cnt]}})};
        s1 = (s  >= qx) ? (s  - qx) : s;
        s2 = (s1 >= qx) ? (s1 - qx) : s1;
    end

    logic [NBITS:0] sum_add, sum_red;
    always_comb begin
        sum_add = {1'b0, acc} + {1'b0, a0};
        sum_red = (sum_add >= {1'b0, Q}) ? (sum_add - {1'b0, Q}) : sum_add;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a0  <= '0;
            a1  <= '0;
            t   <= '0;
            d   <= '0;
            acc <= '0;
            cnt <= '0;
            out <= '0;
        end else begin
            if (accept) begin
                a0 <= in_0;
                a1 <= in_1;
                t  <= tau;
            end
            if (do_sub) begin
                // Modular wrap: when a1 < a0 the NBITS-bit difference plus Q
                // lands back in [0, Q) after natural truncation.
                if (a1 >= a0) d <= a1 - a0;
                else          d <= a1 - a0 + Q;
                acc <= '0;
                cnt <= CW'(NBITS - 1);
            end
            if (do_mul) begin
                acc <= s2[NBITS-1:0];
                cnt <= cnt - 1'b1;
            end
            if (do_add) begin
                out <= sum_red[NBITS-1:0];
            end
        end
    end

endmodule
